tv80_bus_tracer: RTL
====================

# tv80_bus_tracer

Passive bus-cycle tracer on the tv80s external bus. Samples the CPU bus strobes, address and both data buses every clock, classifies each completed cycle (opcode fetch, memory read/write, I/O read/write, interrupt acknowledge), and buffers one record per cycle in a show-ahead FIFO. Maintains free-running event counters. It sits downstream of the CPU, alongside the memory/IO models, and feeds bench checkers and debug readout without driving any CPU input.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256.
- CW, 32, counter width.
- clk  in  1  CPU clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clr  in  1  synchronous clear: flush FIFO, zero counters, clear overflow.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes, active-low.
- A  in  16  CPU address bus.
- di  in  8  data into CPU (read data).
- dout  in  8  data out of CPU (write data).
- trc_valid  out  1  FIFO head valid.
- trc_ready  in  1  consumer accepts head.
- trc_kind  out  3  0=FETCH, 1=MEMRD, 2=MEMWR, 3=IORD, 4=IOWR, 5=INTA.
- trc_addr  out  16  cycle address.
- trc_data  out  8  cycle data.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a record was dropped.
- cnt_m1, cnt_rfsh, cnt_drop  out  CW each  fetch count, refresh count, dropped-record count.

## Operation
- Stage S: all bus inputs registered every rising edge (s_*). Stage P: previous S value (p_*).
- Cycle-end detect (combinational on S/P): end when P shows an active cycle and S does not. Active cycle in P:
  - FETCH: m1_n=0, mreq_n=0, rd_n=0.
  - MEMRD: m1_n=1, mreq_n=0, rd_n=0. MEMWR: mreq_n=0, wr_n=0.
  - IORD: m1_n=1, iorq_n=0, rd_n=0. IOWR: iorq_n=0, wr_n=0. INTA: m1_n=0, iorq_n=0.
  - A cycle ends when its defining strobe set is no longer fully active in S.
- Priority if P matches several kinds: INTA > FETCH > IOWR > IORD > MEMWR > MEMRD.
- Record: kind, addr=p_A, data=p_di for FETCH/MEMRD/IORD/INTA, p_dout for MEMWR/IOWR.
- Refresh (mreq_n=0, rfsh_n=0, rd_n=1) produces no record; cnt_rfsh increments on each P-inactive to S-active transition of rfsh_n&~mreq_n.
- cnt_m1 increments on each FETCH push attempt, dropped or not. All counters wrap mod 2^CW.
- FIFO: push on cycle-end. Pop on trc_valid & trc_ready. Head outputs are registered show-ahead; trc_kind/addr/data hold when trc_valid=0.
- Full: push dropped unless a pop happens the same edge; drop sets overflow, increments cnt_drop. Full + push + pop: both take effect, level unchanged.
- Empty + push + trc_ready=1: no bypass; record appears next edge.
- clr has priority over push/pop/count that edge. Counter and FIFO pointers wrap naturally.
- tracer never drives CPU or memory signals.

## Timing
- Reset/clr values: trc_valid=0, trc_kind=0, trc_addr=0, trc_data=0, level=0, overflow=0, all counters 0, S/P registers idle (all strobes 1).
- Latency: strobe deassertion sampled into S at edge N; push at edge N+1; trc_valid=1 after N+1 when FIFO was empty.
- Consecutive cycles with one idle sample between them produce two records on distinct edges; at most one push per edge.
- Reset asserted mid-cycle: in-flight cycle discarded, no record. After release, cycle already in progress is recorded only if P sees it active (at least one full sample).
- Throughput: one pop per clock when trc_ready held high.

## Test plan
- CPU at PC=0000 with mem[0000]=CB, mem[0001]=91, C=26: exactly two records {FETCH,0000,CB}, {FETCH,0001,91} in order; cnt_m1=2, cnt_rfsh=2; CPU C becomes 22.
- LD (HL),A with HL=97E0, A=5E: records FETCH 0000/77 then {MEMWR,97E0,5E}; mem[97E0]=5E.
- OUT (12),A then IN A,(12) with A=A5: records include {IOWR,xx12,A5} and {IORD,xx12,A5}; no MEMRD for the port cycles.
- DEPTH=4, trc_ready=0, run 6 fetches: level=4, overflow=1, cnt_drop=2, cnt_m1=6; heads are first 4 fetches.
- Full FIFO, trc_ready=1 on the edge of a push: level stays 4, no drop, overflow unchanged.
- Reset pulse mid-instruction with 3 records queued: level=0, trc_valid=0, counters 0 immediately (async); clr=1 for one cycle gives same result synchronously.

Source files
------------

// File: rtl/tv80_bus_tracer.sv
// Passive tv80 bus-cycle tracer: classifies each completed bus cycle and queues one record in a show-ahead FIFO.
// Latency: a strobe release sampled at edge N pushes a record at edge N+1; the head is visible after that edge.
// Backpressure: a pop happens on trc_valid & trc_ready; a push into a full FIFO is dropped unless the same edge pops.
module tv80_bus_tracer #(
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     m1_n,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  input  logic [15:0]              A,
  input  logic [7:0]               di,
  input  logic [7:0]               dout,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [2:0]               trc_kind,
  output logic [15:0]              trc_addr,
  output logic [7:0]               trc_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CW-1:0]            cnt_m1,
  output logic [CW-1:0]            cnt_rfsh,
  output logic [CW-1:0]            cnt_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] K_FETCH = 3'd0;
  localparam logic [2:0] K_MEMRD = 3'd1;
  localparam logic [2:0] K_MEMWR = 3'd2;
  localparam logic [2:0] K_IORD  = 3'd3;
  localparam logic [2:0] K_IOWR  = 3'd4;
  localparam logic [2:0] K_INTA  = 3'd5;

  typedef struct packed {
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [7:0]  dout;
  } bus_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } rec_t;

  // Idle bus: every strobe deasserted, buses zero.
  localparam bus_t BUS_IDLE = '{m1_n: 1'b1, mreq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1,
                                wr_n: 1'b1, rfsh_n: 1'b1, addr: 16'h0, di: 8'h0, dout: 8'h0};

  bus_t            r_s;
  bus_t            r_p;
  rec_t            r_mem [DEPTH];
  rec_t            r_head;
  logic            r_valid;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt_m1;
  logic [CW-1:0]   r_cnt_rfsh;
  logic [CW-1:0]   r_cnt_drop;

  logic [5:0]      w_p_k;
  logic [5:0]      w_s_k;
  logic [2:0]      w_kind;
  logic            w_p_any;
  logic            w_end;
  rec_t            w_rec;
  logic            w_rfsh_rise;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic            w_drop;
  logic [LW-1:0]   w_lvl_after_pop;
  logic [LW-1:0]   w_lvl_nxt;
  logic [AW-1:0]   w_rptr_nxt;

  // One bit per cycle kind whose full strobe set is asserted.
  function automatic logic [5:0] kinds_of(input logic m1, input logic mreq, input logic iorq,
                                          input logic rd, input logic wr);
    logic [5:0] k;
    k          = '0;
    k[K_FETCH] = ~m1 & ~mreq & ~rd;
    k[K_MEMRD] =  m1 & ~mreq & ~rd;
    k[K_MEMWR] = ~mreq & ~wr;
    k[K_IORD]  =  m1 & ~iorq & ~rd;
    k[K_IOWR]  = ~iorq & ~wr;
    k[K_INTA]  = ~m1 & ~iorq;
    return k;
  endfunction

  // Classify P by priority and detect that its defining strobes have released in S.
  always_comb begin
    w_p_k   = kinds_of(r_p.m1_n, r_p.mreq_n, r_p.iorq_n, r_p.rd_n, r_p.wr_n);
    w_s_k   = kinds_of(r_s.m1_n, r_s.mreq_n, r_s.iorq_n, r_s.rd_n, r_s.wr_n);
    w_kind  = K_FETCH;
    w_p_any = 1'b1;
    if (w_p_k[K_INTA])       w_kind = K_INTA;
    else if (w_p_k[K_FETCH]) w_kind = K_FETCH;
    else if (w_p_k[K_IOWR])  w_kind = K_IOWR;
    else if (w_p_k[K_IORD])  w_kind = K_IORD;
    else if (w_p_k[K_MEMWR]) w_kind = K_MEMWR;
    else if (w_p_k[K_MEMRD]) w_kind = K_MEMRD;
    else                     w_p_any = 1'b0;
    w_end       = w_p_any & ~w_s_k[w_kind];
    w_rec.kind  = w_kind;
    w_rec.addr  = r_p.addr;
    w_rec.data  = (w_kind == K_MEMWR || w_kind == K_IOWR) ? r_p.dout : r_p.di;
    w_rfsh_rise = (~r_s.rfsh_n & ~r_s.mreq_n) & ~(~r_p.rfsh_n & ~r_p.mreq_n);
  end

  // FIFO bookkeeping: pop is judged on the registered head, a full FIFO only accepts when popping.
  always_comb begin
    w_pop           = r_valid & trc_ready;
    w_full          = (r_level == LW'(DEPTH));
    w_push          = w_end & (~w_full | w_pop);
    w_drop          = w_end & w_full & ~w_pop;
    w_lvl_after_pop = r_level - LW'(w_pop);
    w_lvl_nxt       = w_lvl_after_pop + LW'(w_push);
    w_rptr_nxt      = r_rptr + AW'(w_pop);
  end

  // Two-deep bus sampling pipeline; returns to idle on reset or clear so in-flight cycles vanish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s <= BUS_IDLE;
      r_p <= BUS_IDLE;
    end else if (clr) begin
      r_s <= BUS_IDLE;
      r_p <= BUS_IDLE;
    end else begin
      r_s <= '{m1_n: m1_n, mreq_n: mreq_n, iorq_n: iorq_n, rd_n: rd_n, wr_n: wr_n,
               rfsh_n: rfsh_n, addr: A, di: di, dout: dout};
      r_p <= r_s;
    end
  end

  // Record storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wptr] <= w_rec;
  end

  // Pointers, occupancy and the registered show-ahead head (holds its last value when empty).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr  <= w_rptr_nxt;
      r_level <= w_lvl_nxt;
      if (w_lvl_nxt == '0) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= 1'b1;
        // A push into a FIFO that is empty after this edge's pop becomes the head directly.
        r_head  <= (w_lvl_after_pop == '0) ? w_rec : r_mem[w_rptr_nxt];
      end
    end
  end

  // Free-running event counters and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_m1   <= '0;
      r_cnt_rfsh <= '0;
      r_cnt_drop <= '0;
      r_ovf      <= 1'b0;
    end else if (clr) begin
      r_cnt_m1   <= '0;
      r_cnt_rfsh <= '0;
      r_cnt_drop <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_end && w_kind == K_FETCH) r_cnt_m1 <= r_cnt_m1 + CW'(1);
      if (w_rfsh_rise)                r_cnt_rfsh <= r_cnt_rfsh + CW'(1);
      if (w_drop) begin
        r_cnt_drop <= r_cnt_drop + CW'(1);
        r_ovf      <= 1'b1;
      end
    end
  end

  assign trc_valid = r_valid;
  assign trc_kind  = r_head.kind;
  assign trc_addr  = r_head.addr;
  assign trc_data  = r_head.data;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign cnt_m1    = r_cnt_m1;
  assign cnt_rfsh  = r_cnt_rfsh;
  assign cnt_drop  = r_cnt_drop;

endmodule
